// File: rtl/alu_pkg.sv
// Shared widths, state encoding and command record for the ALU issue front-end.
package alu_pkg;

  localparam int ALU_OPC_W = 3;
  localparam int ALU_OPD_W = 8;
  localparam int ALU_RES_W = 16;
  localparam int ALU_CMD_W = ALU_OPC_W + 2 * ALU_OPD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_OPC_W-1:0] opcode;
    logic [ALU_OPD_W-1:0] operand1;
    logic [ALU_OPD_W-1:0] operand2;
  } alu_cmd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command stream, ALU drive lines and result stream of alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_OPC_W-1:0] in_opcode;
  logic [ALU_OPD_W-1:0] in_operand1;
  logic [ALU_OPD_W-1:0] in_operand2;

  logic [ALU_OPC_W-1:0] alu_opcode;
  logic [ALU_OPD_W-1:0] alu_operand1;
  logic [ALU_OPD_W-1:0] alu_operand2;
  logic [ALU_RES_W-1:0] alu_result;
  logic                 alu_flagC;
  logic                 alu_flagZ;

  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_RES_W-1:0] out_result;
  logic                 out_flagC;
  logic                 out_flagZ;
  logic [ALU_OPC_W-1:0] out_opcode;

  logic [CNT_W-1:0]     fifo_count;
  logic [15:0]          done_count;

  // The issue controller is the slave of the command/result streams.
  modport slave (
    input  in_valid, in_opcode, in_operand1, in_operand2,
    input  alu_result, alu_flagC, alu_flagZ, out_ready,
    output in_ready, alu_opcode, alu_operand1, alu_operand2,
    output out_valid, out_result, out_flagC, out_flagZ, out_opcode,
    output fifo_count, done_count
  );

  modport master (
    output in_valid, in_opcode, in_operand1, in_operand2,
    output alu_result, alu_flagC, alu_flagZ, out_ready,
    input  in_ready, alu_opcode, alu_operand1, alu_operand2,
    input  out_valid, out_result, out_flagC, out_flagZ, out_opcode,
    input  fifo_count, done_count
  );

endinterface

// File: rtl/alu_issue_ctrl_fifo.sv
// Synchronous command FIFO; full/empty come from the occupancy count, never a bypass.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  alu_cmd_t         wdata,
  input  logic             pop,
  output alu_cmd_t         rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  alu_cmd_t         mem_q [DEPTH];
  alu_cmd_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: queues ALU commands, drives ALU8bit for one cycle, holds the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [ALU_OPC_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [ALU_OPD_W-1:0] alu_operand1_q, alu_operand1_d;
  logic [ALU_OPD_W-1:0] alu_operand2_q, alu_operand2_d;
  logic [ALU_RES_W-1:0] out_result_q, out_result_d;
  logic                 out_flag_c_q, out_flag_c_d;
  logic                 out_flag_z_q, out_flag_z_d;
  logic [ALU_OPC_W-1:0] out_opcode_q, out_opcode_d;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          done_count_q, done_count_d;

  alu_cmd_t             in_cmd, head_cmd;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  assign in_cmd.opcode   = bus.in_opcode;
  assign in_cmd.operand1 = bus.in_operand1;
  assign in_cmd.operand2 = bus.in_operand2;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    alu_opcode_d   = alu_opcode_q;
    alu_operand1_d = alu_operand1_q;
    alu_operand2_d = alu_operand2_q;
    out_result_d   = out_result_q;
    out_flag_c_d   = out_flag_c_q;
    out_flag_z_d   = out_flag_z_q;
    out_opcode_d   = out_opcode_q;
    out_valid_d    = out_valid_q;
    done_count_d   = done_count_q;
    fifo_pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // ALU8bit is combinational: its outputs reflect the drive lines set one edge ago.
        out_result_d = bus.alu_result;
        out_flag_c_d = bus.alu_flagC;
        out_flag_z_d = bus.alu_flagZ;
        out_opcode_d = alu_opcode_q;
        out_valid_d  = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          done_count_d = done_count_q + 16'd1;
          out_valid_d  = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_DRIVE;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_pop) begin
      alu_opcode_d   = head_cmd.opcode;
      alu_operand1_d = head_cmd.operand1;
      alu_operand2_d = head_cmd.operand2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      alu_opcode_q   <= '0;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      out_result_q   <= '0;
      out_flag_c_q   <= 1'b0;
      out_flag_z_q   <= 1'b0;
      out_opcode_q   <= '0;
      out_valid_q    <= 1'b0;
      done_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_operand1_q <= alu_operand1_d;
      alu_operand2_q <= alu_operand2_d;
      out_result_q   <= out_result_d;
      out_flag_c_q   <= out_flag_c_d;
      out_flag_z_q   <= out_flag_z_d;
      out_opcode_q   <= out_opcode_d;
      out_valid_q    <= out_valid_d;
      done_count_q   <= done_count_d;
    end
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_operand1 = alu_operand1_q;
  assign bus.alu_operand2 = alu_operand2_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_flagC    = out_flag_c_q;
  assign bus.out_flagZ    = out_flag_z_q;
  assign bus.out_opcode   = out_opcode_q;
  assign bus.fifo_count   = fifo_count;
  assign bus.done_count   = done_count_q;

endmodule
